// File: rtl/sync_memory_pkg.sv
// mem_defs: shared FSM encoding, default widths and request decode type for sync_memory
package mem_defs;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 7;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    typedef struct packed {
        logic rd;
        logic wr;
        logic bad;
    } req_t;

    function automatic req_t decode_req(input logic acc, input logic rd, input logic wr,
                                        input logic addr_ok);
        req_t r;
        r.rd  = acc & rd & ~wr & addr_ok;
        r.wr  = acc & wr & ~rd & addr_ok;
        r.bad = acc & (rd | wr) & ~(r.rd | r.wr);
        return r;
    endfunction

endpackage

// File: rtl/sync_memory_array.sv
// mem_array: word storage with one synchronous write port and a registered read port, no reset
module mem_array
    import mem_defs::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // write port: callers only assert we_i with an in-range address
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // read register holds its value between reads
    always_ff @(posedge clk) begin
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_memory.sv
// sync_memory: single-port synchronous RAM with clear sequence, read strobe, ready and error flags
module sync_memory
    import mem_defs::*;
#(
    parameter int                       DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int                       ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int                       DEPTH       = 2 ** ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0]    CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  data_valid,
    output logic                  ready,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  valid_q, error_q, seen_q;
    logic                  clearing, addr_ok;
    req_t                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    // state, clear counter and strobe registers; array contents are handled by the clear sequence
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= req.rd;
            error_q <= req.bad;
            seen_q  <= seen_q | req.rd;
        end
    end

    // next state: clear runs DEPTH cycles, a clear request in idle restarts it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d   = cnt_q + ADDR_WIDTH'(1);
            state_d = (cnt_q == LAST) ? ST_IDLE : ST_CLEAR;
        end else if (clear) begin
            cnt_d   = '0;
            state_d = ST_CLEAR;
        end
    end

    // outputs and request decode; clear wins over a simultaneous access
    always_comb begin
        clearing = (state_q == ST_CLEAR);
        ready    = ~clearing;
        addr_ok  = {1'b0, address} < DEPTH_W;
        req      = decode_req(ready & en & ~clear, read, write, addr_ok);
        we       = clearing | req.wr;
        waddr    = clearing ? cnt_q : address;
        wdata    = clearing ? CLEAR_VALUE : input_data;
    end

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .re_i    (req.rd),
        .raddr_i (address),
        .rdata_o (rdata)
    );

    assign output_data = seen_q ? rdata : '0;
    assign data_valid  = valid_q;
    assign error       = error_q;

endmodule

// File: tb/tb_sync_memory.sv
// tb_sync_memory: directed self-checking bench for sync_memory at DEPTH 128 and DEPTH 100
module tb_sync_memory;

    logic       clk = 1'b0;
    logic       rst_n, en, read, write, clear;
    logic [6:0] address;
    logic [7:0] input_data;
    logic [7:0] out_a, out_b;
    logic       dv_a, dv_b, rdy_a, rdy_b, err_a, err_b;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    sync_memory dut (
        .clk(clk), .rst_n(rst_n), .en(en), .read(read), .write(write), .address(address),
        .input_data(input_data), .clear(clear), .output_data(out_a), .data_valid(dv_a),
        .ready(rdy_a), .error(err_a)
    );

    sync_memory #(.DEPTH(100)) dut100 (
        .clk(clk), .rst_n(rst_n), .en(en), .read(read), .write(write), .address(address),
        .input_data(input_data), .clear(clear), .output_data(out_b), .data_valid(dv_b),
        .ready(rdy_b), .error(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic r, input logic w, input logic [6:0] a,
                         input logic [7:0] d);
        en = e; read = r; write = w; address = a; input_data = d;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_ready", rdy_a, 0);
        chk("rst_valid", dv_a, 0);
        chk("rst_error", err_a, 0);
        chk("rst_data", out_a, 0);
        rst_n = 1'b1;
        repeat (99) tick();
        chk("d100_clear_busy", rdy_b, 0);
        tick();
        chk("d100_clear_done", rdy_b, 1);
        repeat (27) tick();
        chk("clear_busy_127", rdy_a, 0);
        tick();
        chk("clear_done_128", rdy_a, 1);
        // read after clear
        drive(1, 1, 0, 5, 0); tick(); drive(0, 0, 0, 0, 0);
        chk("rd5_data", out_a, 8'h00);
        chk("rd5_valid", dv_a, 1);
        tick();
        chk("rd5_valid_drop", dv_a, 0);
        // write then read next cycle
        drive(1, 0, 1, 1, 8'hFF); tick();
        chk("wr1_novalid", dv_a, 0);
        drive(1, 1, 0, 1, 0); tick(); drive(0, 0, 0, 0, 0);
        chk("rd1_data", out_a, 8'hFF);
        chk("rd1_valid", dv_a, 1);
        // back-to-back writes then reads
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 7'(i), 8'(8'h10 + i)); tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 7'(i), 0); tick();
            chk("b2b_data", out_a, 32'(8'h10 + i));
            chk("b2b_valid", dv_a, 1);
        end
        drive(0, 0, 0, 0, 0); tick();
        chk("b2b_valid_drop", dv_a, 0);
        // read and write together
        drive(1, 0, 1, 2, 8'hAA); tick();
        drive(1, 1, 1, 2, 0); tick(); drive(0, 0, 0, 0, 0);
        chk("rw_error", err_a, 1);
        chk("rw_novalid", dv_a, 0);
        chk("rw_data_held", out_a, 8'h13);
        tick();
        chk("rw_error_drop", err_a, 0);
        drive(1, 1, 0, 2, 0); tick(); drive(0, 0, 0, 0, 0);
        chk("rd2_data", out_a, 8'hAA);
        chk("rd2_valid", dv_a, 1);
        // en with no mode
        drive(1, 0, 0, 9, 0); tick(); drive(0, 0, 0, 0, 0);
        chk("noop_error", err_a, 0);
        chk("noop_valid", dv_a, 0);
        // out-of-range on DEPTH=100
        drive(1, 1, 0, 100, 0); tick(); drive(0, 0, 0, 0, 0);
        chk("d100_oor_error", err_b, 1);
        chk("d100_oor_novalid", dv_b, 0);
        chk("d128_addr100_valid", dv_a, 1);
        drive(1, 0, 1, 99, 8'h5A); tick();
        chk("d100_wr99_noerr", err_b, 0);
        drive(1, 1, 0, 99, 0); tick(); drive(0, 0, 0, 0, 0);
        chk("d100_rd99_data", out_b, 8'h5A);
        chk("d100_rd99_valid", dv_b, 1);
        // clear with a simultaneous write
        clear = 1'b1; drive(1, 0, 1, 3, 8'h77); tick();
        clear = 1'b0; drive(0, 0, 0, 0, 0);
        chk("clr_ready_low", rdy_a, 0);
        chk("clr_noerr", err_a, 0);
        chk("clr_novalid", dv_a, 0);
        repeat (127) tick();
        chk("clr_busy_127", rdy_a, 0);
        tick();
        chk("clr_done_128", rdy_a, 1);
        drive(1, 1, 0, 3, 0); tick(); drive(0, 0, 0, 0, 0);
        chk("clr_rd3_data", out_a, 8'h00);
        chk("clr_rd3_valid", dv_a, 1);
        // reset in the middle of a clear
        clear = 1'b1; tick(); clear = 1'b0;
        repeat (50) tick();
        chk("midclr_busy", rdy_a, 0);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("midrst_ready", rdy_a, 0);
        chk("midrst_data", out_a, 0);
        repeat (127) tick();
        chk("midrst_busy_127", rdy_a, 0);
        tick();
        chk("midrst_done_128", rdy_a, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
